rotary_decoder_p: RTL and testbench

- Parametrised successor of the single-shaft rotary check block.
- Takes raw rot_a/rot_b from a quadrature rotary shaft. Synchronises and debounces both channels.
- Derives the same level-type r_event/r_direction flags as before, plus a one-cycle detent pulse and an up/down position counter.
- Sits between the board pins and the LED/display logic of the lab top level.

---
 rtl/rotary_pkg.sv | 28 ++
 rtl/rotary_debounce.sv | 68 ++++++
 rtl/rotary_decoder_p.sv | 125 ++++++++++++
 tb/tb_rotary_decoder_p.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary shaft decoder.
// - Filtered channel states as {A,B} pairs.
// - Direction encodings carried on r_direction / rot_dir.
// - clog2 helper used to size debounce counters.
package rotary_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CW   = 2'b10;
    localparam logic [1:0] ST_CCW  = 2'b01;
    localparam logic [1:0] ST_DET  = 2'b11;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rotary_debounce.sv
// Two-flop synchroniser followed by a stability filter for one shaft channel.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   din   - raw channel, asynchronous to clk
//   dout  - filtered channel; follows the synchronised input only after
//           DEB_CYCLES consecutive differing cycles (DEB_CYCLES=0: no filter)
module rotary_debounce
    import rotary_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             filt_nxt_s;

    // Metastability synchroniser: two flops in series.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter: a change is accepted on the DEB_CYCLES-th differing cycle.
    always_comb begin
        cnt_nxt_s  = '0;
        filt_nxt_s = dout;
        if (DEB_CYCLES == 0) begin
            filt_nxt_s = sync2_r;
        end else if (sync2_r != dout) begin
            if (cnt_r == CNT_LAST) begin
                filt_nxt_s = sync2_r;
                cnt_nxt_s  = '0;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            dout  <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            dout  <= filt_nxt_s;
        end
    end

endmodule

// File: rtl/rotary_decoder_p.sv
// Quadrature rotary shaft decoder with debounce, detent pulse and position.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   rot_a, rot_b  - raw shaft channels
//   pos_clr       - synchronous clear of position (wins over a detent)
//   r_event       - 1 after filtered 11, 0 after filtered 00, else holds
//   r_direction   - 0 after filtered 10, 1 after filtered 01, else holds
//   rot_pulse     - one cycle per rising edge of r_event
//   rot_dir       - direction qualified with rot_pulse
//   position      - detent count (wraps or saturates per WRAP)
//   at_limit      - saturating mode only: position at 0 or all-ones
module rotary_decoder_p
    import rotary_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int POS_W      = 8,
    parameter int STEP       = 1,
    parameter int WRAP       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rot_a,
    input  logic             rot_b,
    input  logic             pos_clr,
    output logic             r_event,
    output logic             r_direction,
    output logic             rot_pulse,
    output logic             rot_dir,
    output logic [POS_W-1:0] position,
    output logic             at_limit
);

    localparam logic [POS_W:0] STEP_X = (POS_W + 1)'(STEP);

    logic             filt_a_s;
    logic             filt_b_s;
    logic             ev_nxt_s;
    logic             dir_nxt_s;
    logic             ev_d_r;
    logic             pulse_nxt_s;
    logic [POS_W:0]   sum_s;
    logic [POS_W:0]   diff_s;
    logic [POS_W-1:0] pos_nxt_s;

    rotary_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rot_a),
        .dout  (filt_a_s)
    );

    rotary_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rot_b),
        .dout  (filt_b_s)
    );

    // Flag decode from the filtered pair; unlisted states hold.
    always_comb begin
        ev_nxt_s  = r_event;
        dir_nxt_s = r_direction;
        case ({filt_a_s, filt_b_s})
            ST_DET:  ev_nxt_s  = 1'b1;
            ST_IDLE: ev_nxt_s  = 1'b0;
            ST_CW:   dir_nxt_s = DIR_CW;
            ST_CCW:  dir_nxt_s = DIR_CCW;
            default: begin
                ev_nxt_s  = r_event;
                dir_nxt_s = r_direction;
            end
        endcase
    end

    // Rising edge of r_event against its one-cycle-delayed copy.
    assign pulse_nxt_s = r_event & ~ev_d_r;

    // Position next value; one guard bit exposes carry/borrow for clamping.
    always_comb begin
        sum_s     = {1'b0, position} + STEP_X;
        diff_s    = {1'b0, position} - STEP_X;
        pos_nxt_s = position;
        if (pos_clr) begin
            pos_nxt_s = '0;
        end else if (rot_pulse) begin
            if (rot_dir == DIR_CW) begin
                if ((WRAP != 0) || !sum_s[POS_W]) begin
                    pos_nxt_s = sum_s[POS_W-1:0];
                end else begin
                    pos_nxt_s = '1;
                end
            end else begin
                if ((WRAP != 0) || !diff_s[POS_W]) begin
                    pos_nxt_s = diff_s[POS_W-1:0];
                end else begin
                    pos_nxt_s = '0;
                end
            end
        end else begin
            pos_nxt_s = position;
        end
    end

    // Flags, pulse and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_event     <= 1'b0;
            r_direction <= 1'b0;
            ev_d_r      <= 1'b0;
            rot_pulse   <= 1'b0;
            rot_dir     <= 1'b0;
            position    <= '0;
        end else begin
            r_event     <= ev_nxt_s;
            r_direction <= dir_nxt_s;
            ev_d_r      <= r_event;
            rot_pulse   <= pulse_nxt_s;
            rot_dir     <= r_direction & pulse_nxt_s;
            position    <= pos_nxt_s;
        end
    end

    assign at_limit = (WRAP == 0) && ((position == '0) || (position == '1));

endmodule

// File: tb/tb_rotary_decoder_p.sv
// Directed bench: one wrapping and one saturating decoder share the stimulus.
module tb_rotary_decoder_p;

    logic       clk;
    logic       rst_n;
    logic       rot_a;
    logic       rot_b;
    logic       pos_clr;

    logic       w_event, w_dir_lvl, w_pulse, w_rdir, w_lim;
    logic [7:0] w_pos;
    logic       s_event, s_dir_lvl, s_pulse, s_rdir, s_lim;
    logic [7:0] s_pos;

    int checks;
    int failures;
    int pulse_cnt;
    int base_cnt;

    rotary_decoder_p #(.DEB_CYCLES(4), .POS_W(8), .STEP(1), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .pos_clr(pos_clr),
        .r_event(w_event), .r_direction(w_dir_lvl), .rot_pulse(w_pulse),
        .rot_dir(w_rdir), .position(w_pos), .at_limit(w_lim)
    );

    rotary_decoder_p #(.DEB_CYCLES(4), .POS_W(8), .STEP(1), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .pos_clr(pos_clr),
        .r_event(s_event), .r_direction(s_dir_lvl), .rot_pulse(s_pulse),
        .rot_dir(s_rdir), .position(s_pos), .at_limit(s_lim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts pulses of the wrapping instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (w_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic detent(input logic ccw);
        rot_a = ~ccw; rot_b = ccw;
        hold(10);
        rot_a = 1'b1; rot_b = 1'b1;
        hold(10);
        rot_a = 1'b0; rot_b = 1'b0;
        hold(10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rot_a = 1'b1; rot_b = 1'b1; pos_clr = 1'b0;
        hold(5);
        checks++;
        if ({w_event, w_dir_lvl, w_pulse, w_rdir, w_pos, w_lim} !== 13'd0) begin
            failures++;
            $display("FAIL reset_wrap_outputs got=%b exp=0", {w_event, w_dir_lvl, w_pulse, w_rdir, w_pos, w_lim});
        end
        checks++;
        if ({s_event, s_dir_lvl, s_pulse, s_rdir, s_pos, s_lim} !== 13'b0_0_0_0_00000000_1) begin
            failures++;
            $display("FAIL reset_sat_outputs got=%b exp=0000000000001", {s_event, s_dir_lvl, s_pulse, s_rdir, s_pos, s_lim});
        end
        rot_a = 1'b0; rot_b = 1'b0;
        hold(2);
        rst_n = 1'b1;
        hold(20);
        checks++;
        if (pulse_cnt !== 0 || w_pos !== 8'd0) begin
            failures++;
            $display("FAIL reset_release pulses=%0d pos=%0d exp pulses=0 pos=0", pulse_cnt, w_pos);
        end
    endtask

    task automatic test_cw_detent;
        base_cnt = pulse_cnt;
        rot_a = 1'b1; rot_b = 1'b0;
        hold(7);
        checks++;
        if (w_dir_lvl !== 1'b0) begin
            failures++;
            $display("FAIL cw_direction got=%b exp=0", w_dir_lvl);
        end
        hold(3);
        rot_a = 1'b1; rot_b = 1'b1;
        hold(6);
        checks++;
        if (w_event !== 1'b0) begin
            failures++;
            $display("FAIL cw_event_early got=%b exp=0", w_event);
        end
        hold(1);
        checks++;
        if (w_event !== 1'b1 || w_pulse !== 1'b0) begin
            failures++;
            $display("FAIL cw_event_latency event=%b pulse=%b exp event=1 pulse=0", w_event, w_pulse);
        end
        hold(1);
        checks++;
        if (w_pulse !== 1'b1 || w_rdir !== 1'b0) begin
            failures++;
            $display("FAIL cw_pulse pulse=%b dir=%b exp pulse=1 dir=0", w_pulse, w_rdir);
        end
        hold(1);
        checks++;
        if (w_pulse !== 1'b0 || w_pos !== 8'd1 || s_pos !== 8'd1) begin
            failures++;
            $display("FAIL cw_position pulse=%b wpos=%0d spos=%0d exp pulse=0 pos=1", w_pulse, w_pos, s_pos);
        end
        hold(1);
        rot_a = 1'b0; rot_b = 1'b0;
        hold(10);
        checks++;
        if (pulse_cnt - base_cnt !== 1) begin
            failures++;
            $display("FAIL cw_single_pulse got=%0d exp=1", pulse_cnt - base_cnt);
        end
    endtask

    task automatic test_ccw_from_zero;
        pos_clr = 1'b1;
        hold(1);
        pos_clr = 1'b0;
        checks++;
        if (w_pos !== 8'd0 || s_pos !== 8'd0) begin
            failures++;
            $display("FAIL clear wpos=%0d spos=%0d exp=0", w_pos, s_pos);
        end
        detent(1'b1);
        checks++;
        if (w_pos !== 8'd255 || w_lim !== 1'b0) begin
            failures++;
            $display("FAIL ccw_wrap pos=%0d lim=%b exp pos=255 lim=0", w_pos, w_lim);
        end
        checks++;
        if (s_pos !== 8'd0 || s_lim !== 1'b1) begin
            failures++;
            $display("FAIL ccw_saturate pos=%0d lim=%b exp pos=0 lim=1", s_pos, s_lim);
        end
        checks++;
        if (w_dir_lvl !== 1'b1 || s_dir_lvl !== 1'b1) begin
            failures++;
            $display("FAIL ccw_direction w=%b s=%b exp=1", w_dir_lvl, s_dir_lvl);
        end
    endtask

    task automatic test_glitch;
        base_cnt = pulse_cnt;
        rot_a = 1'b1;
        hold(3);
        rot_a = 1'b0;
        hold(15);
        checks++;
        if (w_dir_lvl !== 1'b1 || w_event !== 1'b0 || w_pos !== 8'd255 || pulse_cnt !== base_cnt) begin
            failures++;
            $display("FAIL glitch_3clk dir=%b ev=%b pos=%0d pulses=%0d exp dir=1 ev=0 pos=255 pulses=%0d",
                     w_dir_lvl, w_event, w_pos, pulse_cnt, base_cnt);
        end
        rot_a = 1'b1;
        hold(4);
        rot_a = 1'b0;
        hold(15);
        checks++;
        if (w_dir_lvl !== 1'b0 || w_event !== 1'b0 || w_pos !== 8'd255) begin
            failures++;
            $display("FAIL glitch_4clk dir=%b ev=%b pos=%0d exp dir=0 ev=0 pos=255", w_dir_lvl, w_event, w_pos);
        end
    endtask

    task automatic test_clear_collision;
        pos_clr = 1'b1;
        hold(1);
        pos_clr = 1'b0;
        for (int i = 0; i < 5; i++) detent(1'b0);
        checks++;
        if (w_pos !== 8'd5 || s_pos !== 8'd5) begin
            failures++;
            $display("FAIL five_detents wpos=%0d spos=%0d exp=5", w_pos, s_pos);
        end
        rot_a = 1'b1; rot_b = 1'b0;
        hold(10);
        rot_a = 1'b1; rot_b = 1'b1;
        hold(8);
        checks++;
        if (w_pulse !== 1'b1) begin
            failures++;
            $display("FAIL collision_pulse got=%b exp=1", w_pulse);
        end
        pos_clr = 1'b1;
        hold(1);
        pos_clr = 1'b0;
        checks++;
        if (w_pos !== 8'd0 || s_pos !== 8'd0) begin
            failures++;
            $display("FAIL collision_clear wpos=%0d spos=%0d exp=0", w_pos, s_pos);
        end
        rot_a = 1'b0; rot_b = 1'b0;
        hold(12);
    endtask

    task automatic test_async_reset;
        detent(1'b0);
        rot_a = 1'b1; rot_b = 1'b0;
        hold(8);
        checks++;
        if (w_pos !== 8'd1) begin
            failures++;
            $display("FAIL pre_reset_pos got=%0d exp=1", w_pos);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_pos !== 8'd0 || s_pos !== 8'd0 || w_event !== 1'b0 || w_dir_lvl !== 1'b0 || w_pulse !== 1'b0) begin
            failures++;
            $display("FAIL async_reset wpos=%0d spos=%0d ev=%b dir=%b pulse=%b exp all 0",
                     w_pos, s_pos, w_event, w_dir_lvl, w_pulse);
        end
        rot_a = 1'b0; rot_b = 1'b0;
        hold(3);
        rst_n = 1'b1;
        hold(10);
        base_cnt = pulse_cnt;
        detent(1'b0);
        checks++;
        if (w_pos !== 8'd1 || s_pos !== 8'd1 || pulse_cnt - base_cnt !== 1) begin
            failures++;
            $display("FAIL post_reset_detent wpos=%0d spos=%0d pulses=%0d exp pos=1 pulses=1",
                     w_pos, s_pos, pulse_cnt - base_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        pulse_cnt = 0;
        rst_n     = 1'b0;
        rot_a     = 1'b0;
        rot_b     = 1'b0;
        pos_clr   = 1'b0;
        test_reset();
        test_cw_detent();
        test_ccw_from_zero();
        test_glitch();
        test_clear_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
